fc_output_drain: RTL and testbench
==================================

// Module: fc_output_drain
// PURPOSE
//  Drain side of the FC datapath. Captures the WEIGHT_CHANNEL parallel 24-bit accumulator
//  results left by the FC compute stage and requantizes each to BANDWIDTH bits
//  (round, arithmetic shift, saturate). Streams them one channel per handshake over
//  valid/ready to the next layer / activation memory.
// PARAMETERS
//  WEIGHT_CHANNEL  8   number of result lanes captured per vector
//  OUT_BANDWIDTH   24  width of each incoming signed accumulator result
//  BANDWIDTH       8   width of each outgoing signed requantized value
//  SHIFT_W         5   width of requant shift amount (legal 0..OUT_BANDWIDTH-1)
// PORTS
//  clk        in   1                         single clock, rising edge
//  rst        in   1                         synchronous reset, active-high
//  in_valid   in   1                         accumulator vector ready to capture
//  in_ready   out  1                         block can accept a vector
//  in_data    in   OUT_BANDWIDTH x WEIGHT_CHANNEL  signed results, unpacked [WEIGHT_CHANNEL-1:0]
//  shift_amt  in   SHIFT_W                   requant right-shift, sampled with in_data
//  out_valid  out  1                         out_data holds a valid element
//  out_ready  in   1                         downstream accepts element
//  out_data   out  BANDWIDTH                 signed requantized element
//  out_idx    out  $clog2(WEIGHT_CHANNEL)    channel index of out_data
//  out_last   out  1                         high with element WEIGHT_CHANNEL-1
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE, in_ready=1, out_valid=0, out_data=0,
//    out_idx=0, out_last=0, capture regs=0. Reset mid-drain aborts; no element leaks afterwards.
//  - FSM IDLE -> DRAIN on in_valid&&in_ready; DRAIN -> IDLE on out_valid&&out_ready&&out_last.
//  - in_ready = (state==IDLE). Capture: in_data and shift_amt registered on the accept edge.
//  - Latency: out_valid rises the cycle after accept, element 0. out_data/out_idx/out_last registered.
//  - DRAIN: on out_valid&&out_ready, idx++ and the next element is presented the next cycle.
//    No bubbles under continuous out_ready. WEIGHT_CHANNEL elements take WEIGHT_CHANNEL cycles.
//  - out_ready=0: out_data/out_idx/out_last held stable; out_valid never drops until handshake.
//  - After the last handshake: out_valid=0 and in_ready=1 in the same next cycle.
//    New vector accept earliest 1 cycle later (no overlap, no double buffering).
//  - in_valid while not in_ready: ignored; upstream must hold data until accepted.
//  - Requant per element x (OUT_BANDWIDTH signed), s=shift_amt:
//    t = x + (s>0 ? 1<<(s-1) : 0), computed in OUT_BANDWIDTH+1 bits (no wrap).
//    y = t >>> s. Saturate y to [-2^(BANDWIDTH-1), 2^(BANDWIDTH-1)-1].
//  - shift_amt >= OUT_BANDWIDTH: treated as OUT_BANDWIDTH-1.
// CONFIGURATION
//  - FC_RELU_EN defined: negative y clamps to 0 after saturation; range [0, 2^(BANDWIDTH-1)-1].
//  - FC_RELU_EN undefined: signed output as above; no ReLU logic synthesized.
// STRUCTURE
//  - fc_pkg: typedef enum logic {IDLE, DRAIN} drain_state_t.
//    fc_pkg: localparams for sat max/min as functions of BANDWIDTH.
//    fc_pkg: function requant_round_sat shared with any other requant user.
//  - One sub-module fc_requant: combinational single-lane requant (round/shift/sat/ReLU),
//    instantiated once, driven by capture_reg[idx]. Registering of its result is done here.
// TESTING
//  1. rst held 3 cycles, then released -> in_ready=1, out_valid=0, out_data=0, out_idx=0.
//  2. in_data={0,1,..,7}*256, shift=8, out_ready=1 -> outputs 0..7 on consecutive cycles.
//     out_last only at idx 7; in_ready=1 the cycle after.
//  3. Rounding: x=383,s=8 -> 1; x=384,s=8 -> 2; x=-384,s=8 -> -1; x=5,s=0 -> 5.
//  4. Saturation: x=0x7FFFFF,s=4 -> 127; x=-0x800000,s=4 -> -128.
//     With FC_RELU_EN: -128 becomes 0 and -3 becomes 0.
//  5. Backpressure: out_ready toggles 1,0,0,1... -> no element lost or duplicated; data stable while stalled.
//     in_valid pulses during DRAIN are not accepted.
//  6. rst asserted after element 3 handshake -> out_valid=0 next cycle.
//     Next vector drains from idx 0 with fresh data.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types, saturation bounds and the round/shift/saturate requant helper for the FC datapath.
// The FC_RELU_EN option is applied by the requant users, not inside this package.
package fc_pkg;

    typedef enum logic {IDLE, DRAIN} drain_state_t;

    localparam int FC_BANDWIDTH = 8;
    localparam int FC_SAT_MAX   = (1 << (FC_BANDWIDTH - 1)) - 1;
    localparam int FC_SAT_MIN   = -(1 << (FC_BANDWIDTH - 1));

    // Works in 64 bits so the rounding add never wraps for any legal input width.
    // Shift amounts beyond the input width clamp to out_bw-1.
    function automatic logic signed [63:0] requant_round_sat(
        input logic signed [63:0] x,
        input int                 s_in,
        input int                 out_bw,
        input int                 bw
    );
        int                s;
        logic signed [63:0] t, y, hi, lo;
        s  = (s_in >= out_bw) ? out_bw - 1 : s_in;
        t  = x + ((s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0);
        y  = t >>> s;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (y > hi)      y = hi;
        else if (y < lo) y = lo;
        return y;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational single-lane requant: round, arithmetic shift, saturate.
// With FC_RELU_EN defined, negative results clamp to zero.
module fc_requant
    import fc_pkg::*;
#(
    parameter int OUT_BANDWIDTH = 24,
    parameter int BANDWIDTH     = 8,
    parameter int SHIFT_W       = 5
) (
    input  logic signed [OUT_BANDWIDTH-1:0] x,
    input  logic        [SHIFT_W-1:0]       shift,
    output logic signed [BANDWIDTH-1:0]     y
);

    logic signed [63:0] wide;
    logic               unused_hi;

    always_comb begin
        wide = requant_round_sat(64'(x), int'(shift), OUT_BANDWIDTH, BANDWIDTH);
`ifdef FC_RELU_EN
        if (wide < 64'sd0) wide = '0;
`endif
    end

    assign y         = wide[BANDWIDTH-1:0];
    assign unused_hi = ^wide[63:BANDWIDTH];

endmodule

// File: rtl/fc_output_drain.sv
// Captures one vector of accumulator results and streams requantized lanes one per handshake.
// Optional FC_RELU_EN (in fc_requant) clamps negative outputs to zero.
module fc_output_drain
    import fc_pkg::*;
#(
    parameter int WEIGHT_CHANNEL = 8,
    parameter int OUT_BANDWIDTH  = 24,
    parameter int BANDWIDTH      = 8,
    parameter int SHIFT_W        = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [OUT_BANDWIDTH-1:0]   in_data [WEIGHT_CHANNEL-1:0],
    input  logic        [SHIFT_W-1:0]         shift_amt,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [BANDWIDTH-1:0]       out_data,
    output logic [$clog2(WEIGHT_CHANNEL)-1:0] out_idx,
    output logic                              out_last
);

    localparam int IW = $clog2(WEIGHT_CHANNEL);

    drain_state_t                    state;
    logic signed [OUT_BANDWIDTH-1:0] cap [WEIGHT_CHANNEL-1:0];
    logic        [SHIFT_W-1:0]       shift_r;
    logic        [IW-1:0]            nxt_idx;
    logic signed [OUT_BANDWIDTH-1:0] req_x;
    logic        [SHIFT_W-1:0]       req_s;
    logic signed [BANDWIDTH-1:0]     req_y;

    assign nxt_idx = out_idx + 1'b1;

    // On accept, element 0 comes straight from the input so it is ready the next cycle;
    // during drain the lane after the one on display is prepared.
    always_comb begin
        req_x = in_data[0];
        req_s = shift_amt;
        if (state == DRAIN) begin
            req_x = cap[nxt_idx];
            req_s = shift_r;
        end
    end

    fc_requant #(
        .OUT_BANDWIDTH(OUT_BANDWIDTH),
        .BANDWIDTH    (BANDWIDTH),
        .SHIFT_W      (SHIFT_W)
    ) u_requant (
        .x    (req_x),
        .shift(req_s),
        .y    (req_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            shift_r   <= '0;
            for (int i = 0; i < WEIGHT_CHANNEL; i++) cap[i] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cap       <= in_data;
                    shift_r   <= shift_amt;
                    state     <= DRAIN;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                    out_data  <= req_y;
                    out_idx   <= '0;
                    out_last  <= (WEIGHT_CHANNEL == 1);
                end
                DRAIN: if (out_ready) begin
                    if (out_last) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        out_idx  <= nxt_idx;
                        out_data <= req_y;
                        out_last <= (nxt_idx == IW'(WEIGHT_CHANNEL - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_output_drain.sv
// Self-checking bench for fc_output_drain against an arithmetic requant model.
module tb_fc_output_drain;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [23:0] in_data [W-1:0];
    logic        [4:0]  shift_amt;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [2:0]        out_idx;
    logic              out_last;

    int checks = 0;
    int failures = 0;

    int got_d[$];
    int got_i[$];
    int got_l[$];

    fc_output_drain dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .shift_amt(shift_amt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Requant reference: floor division by 2^s after adding half, then clamp.
    function automatic int ref_q(input longint x, input int s_in);
        longint d, t, q;
        int s;
        s = (s_in >= 24) ? 23 : s_in;
        d = 64'sd1 << s;
        t = x + ((s > 0) ? d / 2 : 0);
        q = t / d;
        if ((t % d) != 0 && t < 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`ifdef FC_RELU_EN
        if (q < 0) q = 0;
`endif
        return int'(q);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a vector until accepted (bounded).
    task automatic load(input logic signed [23:0] v [W-1:0], input logic [4:0] s, output bit timeout);
        int n = 0;
        timeout = 0;
        in_data = v;
        shift_amt = s;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) timeout = 1;
        step();
        in_valid = 1'b0;
    endtask

    // Collect one drain. mode 0: always ready, 1: ready 1,0,0 pattern, 2: random.
    task automatic drain(input int mode, input bit poke, output int n, output int cycles,
                         output int bad_stall, output bit end_ok, output bit timeout);
        bit r, stalled;
        logic [7:0] pd;
        logic [2:0] pi;
        logic pl;
        got_d.delete(); got_i.delete(); got_l.delete();
        n = 0; cycles = 0; bad_stall = 0; timeout = 0; stalled = 0;
        pd = '0; pi = '0; pl = 1'b0;
        while (n < W) begin
            if (cycles > 200) begin timeout = 1; break; end
            case (mode)
                0: r = 1'b1;
                1: r = (cycles % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            in_valid = poke && (n < W - 1) && (1'($urandom_range(0, 1)));
            if (poke) for (int i = 0; i < W; i++) in_data[i] = 24'($urandom);
            if (!out_valid) bad_stall++;
            if (stalled && (out_data !== pd || out_idx !== pi || out_last !== pl)) bad_stall++;
            if (r && out_valid) begin
                got_d.push_back(int'(out_data));
                got_i.push_back(int'(out_idx));
                got_l.push_back(int'(out_last));
                n++;
            end
            stalled = !r;
            pd = out_data; pi = out_idx; pl = out_last;
            step();
            cycles++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        end_ok = !out_valid && in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'sd0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%0d out_idx=%0d out_last=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_idx, out_last);
        end
    endtask

    // Drain a vector and compare everything collected against the model.
    task automatic run_and_compare(input string name, input logic signed [23:0] v [W-1:0],
                                   input logic [4:0] s, input int mode, input bit poke);
        int n, cyc, bad; bit eok, to, lto;
        load(v, s, lto);
        checks++;
        if (lto || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: timeout=%0b out_valid=%b in_ready=%b required 0 1 0", name, lto, out_valid, in_ready);
        end
        drain(mode, poke, n, cyc, bad, eok, to);
        checks++;
        if (to || n != W) begin
            failures++;
            $display("FAIL %s count: got %0d elements timeout=%0b required %0d", name, n, to, W);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_d[i] !== ref_q(longint'(v[i]), int'(s)) || got_i[i] !== i || got_l[i] !== int'(i == W - 1)) begin
                failures++;
                $display("FAIL %s elem%0d: data=%0d idx=%0d last=%0d required %0d %0d %0d", name, i,
                         got_d[i], got_i[i], got_l[i], ref_q(longint'(v[i]), int'(s)), i, int'(i == W - 1));
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s stall: %0d unstable/dropped cycles required 0", name, bad);
        end
        checks++;
        if (!eok) begin
            failures++;
            $display("FAIL %s end: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != W) begin
                failures++;
                $display("FAIL %s throughput: %0d cycles required %0d", name, cyc, W);
            end
        end
    endtask

    task automatic test_stream();
        logic signed [23:0] v [W-1:0];
        for (int i = 0; i < W; i++) v[i] = 24'(i * 256);
        run_and_compare("stream", v, 5'd8, 0, 0);
    endtask

    task automatic test_rounding();
        logic signed [23:0] v [W-1:0];
        v = '{24'sd383, 24'sd384, -24'sd384, -24'sd383, 24'sd127, 24'sd128, -24'sd128, -24'sd129};
        run_and_compare("round8", v, 5'd8, 0, 0);
        v = '{24'sd5, -24'sd3, 24'sd0, 24'sd127, -24'sd128, 24'sd128, -24'sd129, 24'sd1};
        run_and_compare("round0", v, 5'd0, 0, 0);
    endtask

    task automatic test_saturation();
        logic signed [23:0] v [W-1:0];
        v = '{24'sh7FFFFF, -24'sh800000, 24'sd2031, 24'sd2032, -24'sd2056, -24'sd2057, -24'sd3, 24'sd0};
        run_and_compare("sat4", v, 5'd4, 0, 0);
        run_and_compare("shiftclamp", v, 5'd31, 0, 0);
    endtask

    task automatic test_backpressure();
        logic signed [23:0] v [W-1:0];
        for (int i = 0; i < W; i++) v[i] = 24'($urandom);
        run_and_compare("bp_pattern", v, 5'd12, 1, 1);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < W; i++) v[i] = 24'($urandom);
            run_and_compare("bp_random", v, 5'($urandom_range(0, 31)), 2, 1);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic signed [23:0] v [W-1:0];
        bit lto;
        int leaks = 0;
        for (int i = 0; i < W; i++) v[i] = 24'($urandom);
        load(v, 5'd6, lto);
        out_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (lto || out_valid !== 1'b1 || out_idx !== 3'd4) begin
            failures++;
            $display("FAIL midrst pre: out_valid=%b out_idx=%0d required 1 4", out_valid, out_idx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 || out_data !== 8'sd0) begin
            failures++;
            $display("FAIL midrst post: out_valid=%b in_ready=%b out_idx=%0d out_data=%0d required 0 1 0 0",
                     out_valid, in_ready, out_idx, out_data);
        end
        repeat (5) begin
            step();
            if (out_valid !== 1'b0) leaks++;
        end
        out_ready = 1'b0;
        checks++;
        if (leaks != 0) begin
            failures++;
            $display("FAIL midrst leak: %0d cycles with out_valid required 0", leaks);
        end
        for (int i = 0; i < W; i++) v[i] = 24'($urandom);
        run_and_compare("after_rst", v, 5'd3, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        shift_amt = '0;
        for (int i = 0; i < W; i++) in_data[i] = '0;
        test_reset();
        test_stream();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
